uart_rx: RTL
============

Name: uart_rx

Overview:
8N1 UART receiver. It takes the asynchronous serial line driven by the peer transmitter, samples each bit at mid-bit using a clock-derived baud divisor, and presents each received byte on a one-entry valid/ready holding register for the core. It is the receive-side counterpart of the UART transmit stage and shares its clock and baud settings.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, line rate in bit/s; DIV = CLK_FREQ/BAUD_RATE (integer division), HALF = DIV/2; legal only if 4 <= DIV <= 65535

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
rx  input  1  asynchronous serial line, idle high
data  output  8  received byte, held stable while valid=1
valid  output  1  data holds an unconsumed byte
ready  input  1  consumer accepts data when valid&&ready
frame_error  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: byte completed while holding register full and not being drained
err_clear  input  1  clears frame_error and overrun
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset, sampled on a clk edge, forces:
  - state=IDLE; baud counter=0; bit index=0; shift register=0.
  - data=0, valid=0, frame_error=0, overrun=0, busy=0.
  - Both synchronizer flops =1.
  - Reset mid-frame abandons the frame with no output.
- Synchronizer: two flops on rx. rx_s (second flop) is the only line value the FSM uses; this adds 2 cycles of latency.
- Baud counter: 16 bit, reset to 0 on every state entry.
- FSM states IDLE, START, DATA, STOP, WAIT_HIGH:
  - IDLE: rx_s==0 -> START.
  - START: when counter==HALF-1, sample rx_s. If 0 -> DATA with bit index=0. If 1 -> IDLE as a glitch; no flags and no output.
  - DATA: when counter==DIV-1, shift right with rx_s entering bit7 (LSB first) and increment bit index. After the 8th sample -> STOP.
  - STOP: when counter==DIV-1, sample rx_s.
    - If 1: the frame is good -> IDLE.
    - If 0: frame_error<=1, byte discarded -> WAIT_HIGH.
  - WAIT_HIGH: stays until rx_s==1, then -> IDLE. This prevents a break condition from being taken as a new start bit.
- Holding register, updated on the good-stop sample edge:
  - If valid==0 or (valid&&ready): data<=shift, valid<=1. Visible the cycle after the edge.
  - If valid&&!ready: overrun<=1; the new byte is dropped and data is unchanged.
  - Otherwise valid&&ready clears valid.
- Sticky flags: err_clear clears both. A set event in the same cycle as err_clear wins (flag ends at 1).
- busy is combinational from state (state!=IDLE).
- Frame length from the first synchronized low to the stop sample = HALF + 9*DIV cycles.

Test Plan:
All scenarios use CLK_FREQ=1_600_000 and BAUD_RATE=100_000 (DIV=16, HALF=8).
1. Frame 0x55 (start, bits LSB-first, stop=1), ready=0 -> valid=1 with data=0x55 and frame_error=0. valid stays 1 until ready is pulsed, then 0 the next cycle.
2. Back-to-back frames 0xA3 then 0x0F, ready tied 1 -> exactly two valid cycles carrying 0xA3 then 0x0F; overrun stays 0.
3. rx low for 3 clocks then high -> no valid and no flags; busy falls after ~HALF cycles; a following 0x3C frame is received correctly.
4. Frame 0x81 with stop=0, line held low 40 cycles then high -> frame_error=1, valid=0, busy=1 until line high. Then err_clear -> frame_error=0.
5. Frames 0x12 then 0x34 with ready=0 -> data remains 0x12 and overrun=1. err_clear coinciding with a third overrun leaves overrun=1.
6. rst asserted during DATA bit 4 of a frame -> next cycle all outputs 0 and busy=0. Line idle, then frame 0xE7 -> data=0xE7, valid=1.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-entry valid/ready holding register.
// Sticky frame_error/overrun flags; a set event in the same cycle as err_clear wins.
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_error,
    output logic       overrun,
    input  logic       err_clear,
    output logic       busy
);
    localparam int DIV  = CLK_FREQ / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        rx_m;
    logic        rx_s;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            data        <= '0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;

            // Clears come first so that set events further down take priority.
            if (err_clear) begin
                frame_error <= 1'b0;
                overrun     <= 1'b0;
            end
            if (valid && ready)
                valid <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s)
                        state <= START;
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == DIV_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            if (!valid || ready) begin
                                data  <= shift;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_error <= 1'b1;
                            state       <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must not be mistaken for a new start bit.
                    cnt <= '0;
                    if (rx_s)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule
